tile_sequencer: RTL and testbench
=================================

Name: tile_sequencer

Overview:
- Frame-level scheduler for the GPU command path: walks the screen tile by tile and issues the full command stream the GPU core's command port expects.
- Per-tile edge-function origins and framebuffer addresses are computed incrementally (adders only, no multipliers).
- Sits in the `clk` domain between CPU-programmed frame registers and the GPU core's Avalon slave command interface; the CPU then only writes one triangle description plus a start.

Parameters:
- TILE_LOG2, 5, log2 of tile edge in pixels (32x32 tiles, matching the tile renderer X/Y width).
- BYTES_LOG2, 1, log2 of bytes per pixel (16bpp).
- TCNT_W, 6, width of the tile-count inputs.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begin a frame
- tiles_x, tiles_y  in  TCNT_W  tiles per row / rows of tiles
- base_addr  in  32  framebuffer byte address of tile (0,0)
- stride  in  16  framebuffer row pitch in bytes
- color  in  16  triangle colour
- a01, a12, a20  in  19 each  signed per-pixel x-step of each edge function
- b01, b12, b20  in  24 each  signed per-pixel y-step
- w0_org, w1_org, w2_org  in  32 each  signed edge values at pixel (0,0)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, last command accepted
- cmd_address  out  4  command register index
- cmd_write  out  1  command write strobe
- cmd_write_data  out  32  command payload
- cmd_wait_request  in  1  command port back-pressure

Behaviour:
- Reset values: busy=0, done=0, cmd_write=0, cmd_address=0, cmd_write_data=0, all internal state idle.
- All inputs are latched on an accepted start (IDLE only). start while busy is ignored.
- Handshake:
  - cmd_write, cmd_address and cmd_write_data are held stable until a cycle with cmd_write=1 and cmd_wait_request=0. That cycle is the acceptance.
  - The next command may be presented the following cycle, so back-to-back writes run at 1 per cycle.
  - cmd_write is never dropped before acceptance.
- States:
  - IDLE -> PRE on start. The first command is driven the cycle after start.
  - PRE issues 9 writes, in order: (0,5) reset; (1,color); (2,a01); (3,a12); (4,a20); (10,b01); (11,b12); (12,b20); (9,stride).
  - If tiles_x==0 or tiles_y==0, PRE goes straight to FLUSH; otherwise PRE -> TILE.
  - TILE issues 6 writes: (8,tile_addr); (5,w0); (6,w1); (7,w2); (0,0) raster; (0,2) write-out. Then TILE -> STEP.
  - STEP takes one cycle and advances tx/ty row-major. It goes to TILE if tiles remain, else to FLUSH.
  - FLUSH issues (0,4). After acceptance it goes to DONE.
  - DONE pulses done for 1 cycle, deasserts busy, and returns to IDLE.
  - busy=1 from the cycle after start through the DONE cycle.
- Arithmetic:
  - a/b are sign-extended to 32 bits before use.
  - xstep_k = a_k << TILE_LOG2; ystep_k = b_k << TILE_LOG2.
  - Row-start registers: wrow_k, starting at w_org, with wrow_k += ystep_k when ty advances.
  - Tile registers: wt_k = wrow_k on each new row, otherwise wt_k += xstep_k.
  - Addresses: tile_addr steps by 1<<(TILE_LOG2+BYTES_LOG2) per tx; the row start steps by stride<<TILE_LOG2 per ty.
  - All sums wrap modulo 2^32 with no saturation.
  - tile (tx,ty) therefore receives w_k = w_org + tx·xstep + ty·ystep and addr = base + ty·(stride<<5) + tx·64.
- Boundaries:
  - tiles_x=1 degenerates to a column walk.
  - Max counts (63x63) must not overflow the counters; counters are TCNT_W wide, compared against the latched count minus 1.
  - cmd_wait_request held high indefinitely stalls with outputs stable.
  - rst mid-frame returns to IDLE on that edge, including the mid-handshake case. Commands already accepted are not retracted; software resets the GPU via the preamble of the next frame.

Optional Feature:
- Macro: TILE_SEQ_CULL_EN.
- When defined, STEP evaluates each edge at the four tile corners: wt, wt+31a, wt+31b, wt+31a+31b (31 = tile size − 1).
- If any single edge is negative at all four corners of the next tile, that tile's TILE phase is skipped. No commands are issued for it; it is stepped over in one cycle and its framebuffer area is untouched.
- Incremental state still advances, so later tiles are unaffected.
- When the macro is undefined, every tile is issued.

Test Plan:
- tiles 2x1, base=0x1000, stride=1280, a01=1, b01=0, w_org all 0, wait_request=0 -> exactly 9+12+1=22 writes with no gaps. Tile 1 gets (8,0x1040) and (5,32). done asserts 1 cycle after the (0,4) acceptance.
- tiles 1x2, stride=1280, b12=-2 -> tile 1 gets addr base+40960 and w1=-64 (0xFFFFFFC0).
- Random wait_request at 50% duty -> command sequence identical to the zero-stall run, and cmd_* are stable whenever wait is high.
- tiles_x=0 -> the 9 preamble writes, then (0,4), then done. No address-8 writes.
- rst asserted on the 3rd write while stalled -> the next cycle shows cmd_write=0, busy=0, and a new start restarts from (0,5).
- CULL_EN, 2x1 tiles, w0_org=-1000, a01=1, b01=0 -> both tiles skipped, giving 10 writes total. Without the macro -> 22 writes.

Source files
------------

// File: rtl/tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tile_sequencer
// Description : Frame scheduler that walks the screen tile by tile and emits
//               the GPU core command stream, with incremental edge/address
//               arithmetic. Optional tile culling under TILE_SEQ_CULL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_sequencer #(
    parameter int TILE_LOG2  = 5,
    parameter int BYTES_LOG2 = 1,
    parameter int TCNT_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TCNT_W-1:0] tiles_x,
    input  logic [TCNT_W-1:0] tiles_y,
    input  logic [31:0]       base_addr,
    input  logic [15:0]       stride,
    input  logic [15:0]       color,
    input  logic [18:0]       a01,
    input  logic [18:0]       a12,
    input  logic [18:0]       a20,
    input  logic [23:0]       b01,
    input  logic [23:0]       b12,
    input  logic [23:0]       b20,
    input  logic [31:0]       w0_org,
    input  logic [31:0]       w1_org,
    input  logic [31:0]       w2_org,
    output logic              busy,
    output logic              done,
    output logic [3:0]        cmd_address,
    output logic              cmd_write,
    output logic [31:0]       cmd_write_data,
    input  logic              cmd_wait_request
);

    localparam logic [2:0]  c_st_idle  = 3'd0;
    localparam logic [2:0]  c_st_pre   = 3'd1;
    localparam logic [2:0]  c_st_tile  = 3'd2;
    localparam logic [2:0]  c_st_step  = 3'd3;
    localparam logic [2:0]  c_st_flush = 3'd4;
    localparam logic [2:0]  c_st_done  = 3'd5;
    localparam logic [31:0] c_tile_bytes = 32'd1 << (TILE_LOG2 + BYTES_LOG2);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [3:0]        r_idx;
    logic [TCNT_W-1:0] r_tx, r_ty, r_tx_max, r_ty_max;
    logic              r_empty;
    logic [15:0]       r_color, r_stride;
    logic [31:0]       r_a [3];
    logic [31:0]       r_b [3];
    logic [31:0]       r_wrow [3];
    logic [31:0]       r_wt [3];
    logic [31:0]       r_row_addr, r_tile_addr;

    logic [31:0]       w_nwrow [3];
    logic [31:0]       w_nwt [3];
    logic [31:0]       w_nrow_addr, w_ntile_addr, w_row_step;
    logic              w_row_end, w_last, w_accept;
    logic              w_cull_cur, w_cull_nxt;

    assign w_row_end  = (r_tx == r_tx_max);
    assign w_last     = w_row_end && (r_ty == r_ty_max);
    assign w_row_step = {16'd0, r_stride} << TILE_LOG2;
    assign w_accept   = cmd_write & ~cmd_wait_request;
    assign busy       = (r_state != c_st_idle);
    assign done       = (r_state == c_st_done);

    // Values of the tile that follows the current one in row-major order
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            if (w_row_end) begin
                w_nwrow[k] = r_wrow[k] + (r_b[k] << TILE_LOG2);
                w_nwt[k]   = w_nwrow[k];
            end else begin
                w_nwrow[k] = r_wrow[k];
                w_nwt[k]   = r_wt[k] + (r_a[k] << TILE_LOG2);
            end
        end
        if (w_row_end) begin
            w_nrow_addr  = r_row_addr + w_row_step;
            w_ntile_addr = w_nrow_addr;
        end else begin
            w_nrow_addr  = r_row_addr;
            w_ntile_addr = r_tile_addr + c_tile_bytes;
        end
    end

`ifdef TILE_SEQ_CULL_EN
    // An edge rejects the tile when it is negative at all four corners
    function automatic logic f_edge_out(input logic [31:0] wt, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] a_span, b_span, c1, c2, c3;
        a_span = (a << TILE_LOG2) - a;
        b_span = (b << TILE_LOG2) - b;
        c1 = wt + a_span;
        c2 = wt + b_span;
        c3 = c1 + b_span;
        return wt[31] & c1[31] & c2[31] & c3[31];
    endfunction

    always_comb begin
        w_cull_cur = 1'b0;
        w_cull_nxt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w_cull_cur = w_cull_cur | f_edge_out(r_wt[k], r_a[k], r_b[k]);
            w_cull_nxt = w_cull_nxt | f_edge_out(w_nwt[k], r_a[k], r_b[k]);
        end
    end
`else
    assign w_cull_cur = 1'b0;
    assign w_cull_nxt = 1'b0;
`endif

    always_comb begin
        cmd_write      = 1'b0;
        cmd_address    = 4'd0;
        cmd_write_data = 32'd0;
        case (r_state)
            c_st_pre: begin
                cmd_write = 1'b1;
                case (r_idx)
                    4'd0:    begin cmd_address = 4'd0;  cmd_write_data = 32'd5;              end
                    4'd1:    begin cmd_address = 4'd1;  cmd_write_data = {16'd0, r_color};   end
                    4'd2:    begin cmd_address = 4'd2;  cmd_write_data = r_a[0];             end
                    4'd3:    begin cmd_address = 4'd3;  cmd_write_data = r_a[1];             end
                    4'd4:    begin cmd_address = 4'd4;  cmd_write_data = r_a[2];             end
                    4'd5:    begin cmd_address = 4'd10; cmd_write_data = r_b[0];             end
                    4'd6:    begin cmd_address = 4'd11; cmd_write_data = r_b[1];             end
                    4'd7:    begin cmd_address = 4'd12; cmd_write_data = r_b[2];             end
                    default: begin cmd_address = 4'd9;  cmd_write_data = {16'd0, r_stride};  end
                endcase
            end
            c_st_tile: begin
                cmd_write = 1'b1;
                case (r_idx)
                    4'd0:    begin cmd_address = 4'd8; cmd_write_data = r_tile_addr; end
                    4'd1:    begin cmd_address = 4'd5; cmd_write_data = r_wt[0];     end
                    4'd2:    begin cmd_address = 4'd6; cmd_write_data = r_wt[1];     end
                    4'd3:    begin cmd_address = 4'd7; cmd_write_data = r_wt[2];     end
                    4'd4:    begin cmd_address = 4'd0; cmd_write_data = 32'd0;       end
                    default: begin cmd_address = 4'd0; cmd_write_data = 32'd2;       end
                endcase
            end
            c_st_flush: begin
                cmd_write      = 1'b1;
                cmd_write_data = 32'd4;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (start) w_state_nxt = c_st_pre;
            c_st_pre:   if (w_accept && r_idx == 4'd8)
                            w_state_nxt = r_empty ? c_st_flush :
                                          (w_cull_cur ? c_st_step : c_st_tile);
            c_st_tile:  if (w_accept && r_idx == 4'd5) w_state_nxt = c_st_step;
            c_st_step:  w_state_nxt = w_last ? c_st_flush :
                                      (w_cull_nxt ? c_st_step : c_st_tile);
            c_st_flush: if (w_accept) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_st_idle: if (start) begin
                    r_idx       <= 4'd0;
                    r_tx        <= '0;
                    r_ty        <= '0;
                    r_tx_max    <= tiles_x - TCNT_W'(1);
                    r_ty_max    <= tiles_y - TCNT_W'(1);
                    r_empty     <= (tiles_x == '0) || (tiles_y == '0);
                    r_color     <= color;
                    r_stride    <= stride;
                    r_a[0]      <= {{13{a01[18]}}, a01};
                    r_a[1]      <= {{13{a12[18]}}, a12};
                    r_a[2]      <= {{13{a20[18]}}, a20};
                    r_b[0]      <= {{8{b01[23]}}, b01};
                    r_b[1]      <= {{8{b12[23]}}, b12};
                    r_b[2]      <= {{8{b20[23]}}, b20};
                    r_wrow[0]   <= w0_org;
                    r_wrow[1]   <= w1_org;
                    r_wrow[2]   <= w2_org;
                    r_wt[0]     <= w0_org;
                    r_wt[1]     <= w1_org;
                    r_wt[2]     <= w2_org;
                    r_row_addr  <= base_addr;
                    r_tile_addr <= base_addr;
                end
                c_st_pre:  if (w_accept) r_idx <= (r_idx == 4'd8) ? 4'd0 : r_idx + 4'd1;
                c_st_tile: if (w_accept) r_idx <= (r_idx == 4'd5) ? 4'd0 : r_idx + 4'd1;
                c_st_step: if (!w_last) begin
                    r_tx        <= w_row_end ? '0 : r_tx + TCNT_W'(1);
                    r_ty        <= w_row_end ? r_ty + TCNT_W'(1) : r_ty;
                    r_row_addr  <= w_nrow_addr;
                    r_tile_addr <= w_ntile_addr;
                    for (int k = 0; k < 3; k++) begin
                        r_wrow[k] <= w_nwrow[k];
                        r_wt[k]   <= w_nwt[k];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_sequencer
// Description : Directed self-checking bench for tile_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  tiles_x = '0, tiles_y = '0;
    logic [31:0] base_addr = '0;
    logic [15:0] stride = '0, color = '0;
    logic [18:0] a01 = '0, a12 = '0, a20 = '0;
    logic [23:0] b01 = '0, b12 = '0, b20 = '0;
    logic [31:0] w0_org = '0, w1_org = '0, w2_org = '0;
    logic        busy, done, cmd_write, cmd_wait_request;
    logic [3:0]  cmd_address;
    logic [31:0] cmd_write_data;

    logic rand_en = 1'b0, r_rand = 1'b0, wait_hold = 1'b0;
    assign cmd_wait_request = rand_en ? r_rand : wait_hold;

    always #5 clk = ~clk;

    tile_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .tiles_x(tiles_x), .tiles_y(tiles_y),
        .base_addr(base_addr), .stride(stride), .color(color),
        .a01(a01), .a12(a12), .a20(a20), .b01(b01), .b12(b12), .b20(b20),
        .w0_org(w0_org), .w1_org(w1_org), .w2_org(w2_org),
        .busy(busy), .done(done), .cmd_address(cmd_address), .cmd_write(cmd_write),
        .cmd_write_data(cmd_write_data), .cmd_wait_request(cmd_wait_request)
    );

    always @(posedge clk) begin
        #1;
        r_rand = 1'($urandom_range(0, 1));
    end

    // Command-port observer: logs acceptances and checks stall stability
    logic [35:0] q[$];
    logic [35:0] exp_q[$];
    int cyc = 0, last_acc = 0, done_cyc = 0, stall_bad = 0, stall_cnt = 0;
    logic p_stall = 1'b0, p_rst = 1'b0;
    logic [3:0]  p_addr = '0;
    logic [31:0] p_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (p_stall && !p_rst &&
            (!cmd_write || cmd_address !== p_addr || cmd_write_data !== p_data))
            stall_bad++;
        if (cmd_write && !cmd_wait_request) begin
            q.push_back({cmd_address, cmd_write_data});
            last_acc = cyc;
        end
        if (cmd_write && cmd_wait_request) stall_cnt++;
        if (done) done_cyc = cyc;
        p_stall = cmd_write && cmd_wait_request;
        p_addr  = cmd_address;
        p_data  = cmd_write_data;
        p_rst   = rst;
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_pre(input logic [31:0] col, input logic [31:0] x0, input logic [31:0] x1,
                            input logic [31:0] x2, input logic [31:0] y0, input logic [31:0] y1,
                            input logic [31:0] y2, input logic [31:0] str);
        exp_q.push_back({4'd0, 32'd5});  exp_q.push_back({4'd1, col});
        exp_q.push_back({4'd2, x0});     exp_q.push_back({4'd3, x1});
        exp_q.push_back({4'd4, x2});     exp_q.push_back({4'd10, y0});
        exp_q.push_back({4'd11, y1});    exp_q.push_back({4'd12, y2});
        exp_q.push_back({4'd9, str});
    endtask

    task automatic push_tile(input logic [31:0] ad, input logic [31:0] v0, input logic [31:0] v1,
                             input logic [31:0] v2);
        exp_q.push_back({4'd8, ad}); exp_q.push_back({4'd5, v0});
        exp_q.push_back({4'd6, v1}); exp_q.push_back({4'd7, v2});
        exp_q.push_back({4'd0, 32'd0}); exp_q.push_back({4'd0, 32'd2});
    endtask

    task automatic compare_q(input string tag);
        logic [63:0] obs;
        check({tag, "_len"}, 64'(q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < q.size()) ? 64'(q[i]) : 64'hDEAD_0000_0000_0000;
            check($sformatf("%s[%0d]", tag, i), obs, 64'(exp_q[i]));
        end
    endtask

    // Pulses start, optionally re-pulses it mid-frame, waits for done
    task automatic run_frame(input int limit, input bit inject, output int cycles);
        q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cycles = 0;
        while (!done && cycles < limit) begin
            @(negedge clk);
            cycles++;
            start = (inject && cycles == 5);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cfg_t1();
        tiles_x = 6'd2; tiles_y = 6'd1; base_addr = 32'h1000; stride = 16'd1280;
        color = 16'hBEEF; a01 = 19'd1; a12 = 19'h7FFFD; a20 = '0;
        b01 = '0; b12 = '0; b20 = 24'd5; w0_org = '0; w1_org = 32'd100; w2_org = '0;
    endtask

    int cycles;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_write", 64'(cmd_write), 64'd0);
        check("rst_addr", 64'(cmd_address), 64'd0);
        check("rst_data", 64'(cmd_write_data), 64'd0);

        // 2x1 frame, no stalls
        cfg_t1();
        exp_q.delete();
        push_pre(32'hBEEF, 32'd1, 32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0, 32'd5, 32'd1280);
        push_tile(32'h1000, 32'd0, 32'd100, 32'd0);
        push_tile(32'h1040, 32'd32, 32'd4, 32'd0);
        exp_q.push_back({4'd0, 32'd4});
        run_frame(200, 1'b0, cycles);
        compare_q("t1");
        check("t1_cycles", 64'(cycles), 64'd25);
        check("t1_done_lat", 64'(done_cyc), 64'(last_acc + 1));
        check("t1_idle", 64'(busy), 64'd0);
        check("t1_done_pulse", 64'(done), 64'd0);

        // Same frame with random back-pressure and a stray start mid-frame
        stall_bad = 0; stall_cnt = 0; rand_en = 1'b1;
        run_frame(400, 1'b1, cycles);
        rand_en = 1'b0;
        compare_q("t2");
        check("t2_done_seen", 64'(cycles < 400), 64'd1);
        check("t2_stalled", 64'(stall_cnt > 0), 64'd1);
        check("t2_stable", 64'(stall_bad), 64'd0);

        // 1x2 column walk with negative y-step
        tiles_x = 6'd1; tiles_y = 6'd2; base_addr = 32'h2000; stride = 16'd1280;
        color = '0; a01 = '0; a12 = '0; a20 = '0; b01 = '0; b12 = 24'hFFFFFE; b20 = '0;
        w0_org = '0; w1_org = '0; w2_org = '0;
        exp_q.delete();
        push_pre(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0, 32'd1280);
        push_tile(32'h2000, 32'd0, 32'd0, 32'd0);
        push_tile(32'hC000, 32'd0, 32'hFFFF_FFC0, 32'd0);
        exp_q.push_back({4'd0, 32'd4});
        run_frame(200, 1'b0, cycles);
        compare_q("t3");
        check("t3_cycles", 64'(cycles), 64'd25);

        // Empty frame: tiles_x == 0
        cfg_t1();
        tiles_x = '0; tiles_y = 6'd3;
        exp_q.delete();
        push_pre(32'hBEEF, 32'd1, 32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0, 32'd5, 32'd1280);
        exp_q.push_back({4'd0, 32'd4});
        run_frame(200, 1'b0, cycles);
        compare_q("t4");
        check("t4_cycles", 64'(cycles), 64'd11);

        // Reset while the third preamble write is stalled
        cfg_t1();
        stall_bad = 0;
        q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 wait_hold = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_held_write", 64'(cmd_write), 64'd1);
        check("t5_held_addr", 64'(cmd_address), 64'd2);
        check("t5_held_data", 64'(cmd_write_data), 64'd1);
        check("t5_accepted", 64'(q.size()), 64'd2);
        check("t5_stable", 64'(stall_bad), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("t5_rst_write", 64'(cmd_write), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        wait_hold = 1'b0;
        exp_q.delete();
        push_pre(32'hBEEF, 32'd1, 32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0, 32'd5, 32'd1280);
        push_tile(32'h1000, 32'd0, 32'd100, 32'd0);
        push_tile(32'h1040, 32'd32, 32'd4, 32'd0);
        exp_q.push_back({4'd0, 32'd4});
        run_frame(200, 1'b0, cycles);
        compare_q("t5_restart");

        // Fully negative edge 0: culled when the feature is built in
        tiles_x = 6'd2; tiles_y = 6'd1; base_addr = 32'h1000; stride = 16'd1280;
        color = '0; a01 = 19'd1; a12 = '0; a20 = '0; b01 = '0; b12 = '0; b20 = '0;
        w0_org = -32'sd1000; w1_org = '0; w2_org = '0;
        run_frame(200, 1'b0, cycles);
`ifdef TILE_SEQ_CULL_EN
        check("t6_writes", 64'(q.size()), 64'd10);
        check("t6_cycles", 64'(cycles), 64'd13);
`else
        check("t6_writes", 64'(q.size()), 64'd22);
        check("t6_cycles", 64'(cycles), 64'd25);
`endif
        check("t6_last", (q.size() > 0) ? 64'(q[q.size()-1]) : 64'd0, 64'({4'd0, 32'd4}));

        // Maximum tile counts
        tiles_x = 6'd63; tiles_y = 6'd63; base_addr = '0; stride = 16'd2048;
        a01 = '0; w0_org = '0;
        run_frame(30000, 1'b0, cycles);
        check("t7_writes", 64'(q.size()), 64'd23824);
        check("t7_cycles", 64'(cycles), 64'd27794);
        check("t7_last_addr", (q.size() > 23817) ? 64'(q[23817]) : 64'd0,
              64'({4'd8, 32'h003E_0F80}));
        check("t7_flush", (q.size() > 23823) ? 64'(q[23823]) : 64'd0, 64'({4'd0, 32'd4}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
